// File: rtl/prim_onehot_rr_arbiter.sv
// Hardened round-robin arbiter: N requesters share one valid/ready channel.
// Ownership is held as a one-hot vector plus a binary index; the two are
// cross-checked every cycle, and any fault parks the block in a sticky error state.
module prim_onehot_rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned DW = 32,
  localparam int unsigned IdxW = $clog2(N)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [N-1:0]      req_i,
  input  logic [N*DW-1:0]   data_i,
  output logic              valid_o,
  output logic [DW-1:0]     data_o,
  output logic [IdxW-1:0]   idx_o,
  input  logic              ready_i,
  output logic [N-1:0]      gnt_o,
  output logic              err_o
);

  // Sparse encoding: every pair of legal states differs in at least 3 bits.
  typedef enum logic [5:0] {
    StIdle  = 6'b000111,
    StBusy  = 6'b111000,
    StError = 6'b101101
  } state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    owner_q, owner_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic            err_q, err_d;

  logic            valid_q;
  logic            hs;
  logic [N-1:0]    cand;
  logic            win_valid;
  logic [IdxW-1:0] win_idx;
  logic [N-1:0]    win_oh;
  logic [N-1:0]    oh_exp;
  logic            oh_err;
  logic            req_sel;
  logic            proto_err;
  logic            enc_err;
  logic            load;
  logic [DW-1:0]   data_sel;

  assign valid_q = (state_q == StBusy);
  assign hs      = valid_q & ready_i;

  // Candidate mask: the owner being served in the handshake cycle is excluded.
  always_comb begin
    cand = (state_q == StIdle) ? req_i : (req_i & ~owner_q);
  end

  // Round-robin pick: first candidate found scanning upward from ptr_q with wrap.
  always_comb begin
    int j;
    win_valid = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < int'(N); k++) begin
      j = (int'(ptr_q) + k) % int'(N);
      if (!win_valid && cand[j]) begin
        win_valid = 1'b1;
        win_idx   = IdxW'(j);
      end
    end
  end

  // One-hot form of the winner, and the owner vector the index implies.
  always_comb begin
    win_oh = '0;
    oh_exp = '0;
    for (int i = 0; i < int'(N); i++) begin
      win_oh[i] = (win_idx == IdxW'(i));
      oh_exp[i] = valid_q && (idx_q == IdxW'(i));
    end
  end

  // Onehot check (strict enable + address): owner must equal onehot(idx) when busy, zero otherwise.
  assign oh_err = (owner_q != oh_exp);

  // Owner's request line and payload, selected by the binary index.
  always_comb begin
    req_sel  = 1'b0;
    data_sel = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (idx_q == IdxW'(i)) begin
        req_sel  = req_i[i];
        data_sel = data_i[i*DW +: DW];
      end
    end
  end

  // A request withdrawn before its grant is a protocol violation.
  assign proto_err = valid_q & ~req_sel;

  // Next-state logic: arbitration, handshake, and fault capture.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    err_d   = err_q;
    load    = 1'b0;
    enc_err = 1'b0;

    case (state_q)
      StIdle: begin
        load = win_valid;
      end
      StBusy: begin
        if (hs) begin
          if (win_valid) begin
            load = 1'b1;
          end else begin
            state_d = StIdle;
            owner_d = '0;
            idx_d   = '0;
          end
        end
      end
      StError: begin
        owner_d = '0;
        idx_d   = '0;
      end
      default: enc_err = 1'b1;
    endcase

    if (load) begin
      state_d = StBusy;
      owner_d = win_oh;
      idx_d   = win_idx;
      ptr_d   = (win_idx == IdxW'(N - 1)) ? '0 : win_idx + IdxW'(1);
    end

    if ((state_q != StError) && (oh_err || proto_err || enc_err)) begin
      state_d = StError;
      err_d   = 1'b1;
      owner_d = '0;
      idx_d   = '0;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      owner_q <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
    end
  end

  // Outputs: valid is registered only; gnt follows ready combinationally.
  assign valid_o = valid_q;
  assign idx_o   = valid_q ? idx_q : '0;
  assign data_o  = valid_q ? data_sel : '0;
  assign gnt_o   = owner_q & {N{hs}};
  assign err_o   = err_q;

endmodule

// File: tb/tb_prim_onehot_rr_arbiter.sv
// Self-checking bench for prim_onehot_rr_arbiter (N=4, DW=32).
module tb_prim_onehot_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*DW-1:0] data = '0;
  logic            ready = 1'b0;
  logic            valid;
  logic [DW-1:0]   dout;
  logic [1:0]      idx;
  logic [N-1:0]    gnt;
  logic            err;

  int n_checks = 0;
  int n_errs   = 0;

  prim_onehot_rr_arbiter #(.N(N), .DW(DW)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .req_i   (req),
    .data_i  (data),
    .valid_o (valid),
    .data_o  (dout),
    .idx_o   (idx),
    .ready_i (ready),
    .gnt_o   (gnt),
    .err_o   (err)
  );

  always #5 clk = ~clk;

  localparam logic [N*DW-1:0] FixedData =
    {32'hD3D3_0003, 32'hC2C2_0002, 32'hB1B1_0001, 32'hA0A0_0000};

  typedef struct {
    bit         rst;
    logic [3:0] req;
    logic       ready;
    logic       ev;
    logic [1:0] eidx;
    logic [3:0] egnt;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string name, input logic ev, input int eidx,
                          input logic [3:0] egnt, input logic eerr);
    logic [DW-1:0] ed;
    ed = ev ? data[eidx*DW +: DW] : '0;
    chk({name, ".valid"}, 64'(valid), 64'(ev));
    chk({name, ".idx"},   64'(idx),   ev ? 64'(eidx) : 64'd0);
    chk({name, ".gnt"},   64'(gnt),   64'(egnt));
    chk({name, ".data"},  64'(dout),  64'(ed));
    chk({name, ".err"},   64'(err),   64'(eerr));
  endtask

  // Ends one time unit after a rising edge with reset released.
  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    ready = 1'b0;
    #1;
    chk_outs("reset", 1'b0, 0, 4'b0000, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Reference model state: who owns the channel and where the scan starts.
  bit m_busy;
  int m_own;
  int m_ptr;

  function automatic void model_pick(input logic [3:0] m);
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (m[c]) begin
        m_own  = c;
        m_ptr  = (c + 1) % N;
        m_busy = 1'b1;
        return;
      end
    end
    m_busy = 1'b0;
    m_own  = 0;
  endfunction

  vec_t vecs[$];

  initial begin
    // Tests 1-4 as a cycle-by-cycle table; rst forces a reset before the row.
    vecs = '{
      '{1, 4'b0100, 1, 0, 0, 4'b0000},
      '{0, 4'b0100, 1, 1, 2, 4'b0100},
      '{0, 4'b0000, 1, 0, 0, 4'b0000},
      '{0, 4'b0000, 1, 0, 0, 4'b0000},
      '{1, 4'b1111, 1, 0, 0, 4'b0000},
      '{0, 4'b1111, 1, 1, 0, 4'b0001},
      '{0, 4'b1111, 1, 1, 1, 4'b0010},
      '{0, 4'b1111, 1, 1, 2, 4'b0100},
      '{0, 4'b1111, 1, 1, 3, 4'b1000},
      '{0, 4'b1111, 1, 1, 0, 4'b0001},
      '{1, 4'b0100, 1, 0, 0, 4'b0000},
      '{0, 4'b0100, 1, 1, 2, 4'b0100},
      '{0, 4'b0011, 1, 0, 0, 4'b0000},
      '{0, 4'b0011, 1, 1, 0, 4'b0001},
      '{0, 4'b0010, 1, 1, 1, 4'b0010},
      '{0, 4'b0000, 1, 0, 0, 4'b0000},
      '{1, 4'b0010, 0, 0, 0, 4'b0000},
      '{0, 4'b1011, 0, 1, 1, 4'b0000},
      '{0, 4'b1011, 0, 1, 1, 4'b0000},
      '{0, 4'b1011, 0, 1, 1, 4'b0000},
      '{0, 4'b1011, 0, 1, 1, 4'b0000},
      '{0, 4'b1011, 0, 1, 1, 4'b0000},
      '{0, 4'b1011, 1, 1, 1, 4'b0010},
      '{0, 4'b1001, 1, 1, 3, 4'b1000},
      '{0, 4'b0001, 1, 1, 0, 4'b0001},
      '{0, 4'b0000, 0, 0, 0, 4'b0000}
    };

    data = FixedData;
    @(posedge clk);
    #1;
    foreach (vecs[r]) begin
      if (vecs[r].rst) do_reset();
      req   = vecs[r].req;
      ready = vecs[r].ready;
      @(negedge clk);
      chk_outs($sformatf("vec%0d", r), vecs[r].ev, int'(vecs[r].eidx), vecs[r].egnt, 1'b0);
      @(posedge clk);
      #1;
    end

    // Corrupted owner vector while busy.
    do_reset();
    req = 4'b0010;
    @(posedge clk);
    #1;
    force dut.owner_q = 4'b0110;
    @(negedge clk);
    chk("oh_force.err_latency", 64'(err), 64'd0);
    @(posedge clk);
    #1;
    release dut.owner_q;
    ready = 1'b1;
    @(negedge clk);
    chk_outs("oh_force", 1'b0, 0, 4'b0000, 1'b1);
    req = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk_outs($sformatf("oh_sticky%0d", c), 1'b0, 0, 4'b0000, 1'b1);
    end
    @(posedge clk);
    #1;
    do_reset();

    // Index disagreeing with owner vector while busy.
    req = 4'b0010;
    @(posedge clk);
    #1;
    force dut.idx_q = 2'd3;
    @(posedge clk);
    #1;
    release dut.idx_q;
    @(negedge clk);
    chk_outs("idx_force", 1'b0, 0, 4'b0000, 1'b1);
    @(posedge clk);
    #1;
    do_reset();

    // Owner withdraws its request before being accepted.
    req = 4'b0010;
    @(posedge clk);
    #1;
    req = 4'b0000;
    @(negedge clk);
    chk("withdraw.err_latency", 64'(err), 64'd0);
    @(posedge clk);
    #1;
    req   = 4'b0100;
    ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk_outs($sformatf("withdraw%0d", c), 1'b0, 0, 4'b0000, 1'b1);
    end
    @(posedge clk);
    #1;
    do_reset();

    // Reset mid-transfer: no grant reaches the owner.
    req = 4'b0010;
    @(posedge clk);
    @(negedge clk);
    chk_outs("mid_busy", 1'b1, 1, 4'b0000, 1'b0);
    @(posedge clk);
    #1;
    ready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk_outs("mid_rst_async", 1'b0, 0, 4'b0000, 1'b0);
    @(negedge clk);
    chk_outs("mid_rst_hold", 1'b0, 0, 4'b0000, 1'b0);
    @(posedge clk);
    #1;
    do_reset();

    // Randomized traffic against the reference model.
    begin
      logic [3:0] gnt_prev;
      logic [3:0] egnt;
      logic [DW-1:0] ed;
      gnt_prev = '0;
      m_busy   = 1'b0;
      m_own    = 0;
      m_ptr    = 0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
        for (int i = 0; i < N; i++) begin
          if (gnt_prev[i]) begin
            req[i] = 1'b0;
          end else if (!req[i] && $urandom_range(0, 3) == 0) begin
            req[i] = 1'b1;
            data[i*DW +: DW] = $urandom;
          end
        end
        ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        egnt = (m_busy && ready) ? 4'(1 << m_own) : 4'b0000;
        ed   = m_busy ? data[m_own*DW +: DW] : '0;
        chk($sformatf("rand%0d", cyc), {24'd0, valid, idx, gnt, err, dout},
            {24'd0, m_busy, m_busy ? 2'(m_own) : 2'd0, egnt, 1'b0, ed});
        gnt_prev = egnt;
        if (m_busy) begin
          if (ready) model_pick(req & ~4'(1 << m_own));
        end else if (req != 0) begin
          model_pick(req);
        end
        @(posedge clk);
        #1;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
